// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Build option: IF_PREFETCH_BUF_EN selects a two-deep prefetch path;
// without it the fetch path holds a single instruction.
package if_stage_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef IF_PREFETCH_BUF_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// In-order instruction buffer of DEPTH entries, each carrying {pc, instruction}.
// Entry 0 is always the head, so the head is a plain register read.
// A push and a pop in the same cycle are accepted even when full.
// The head output reads as zero while the buffer is empty.
module fetch_fifo #(
    parameter int   DEPTH = 1,
    parameter int   W     = 64,
    localparam int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic          valid,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem      [DEPTH];
    logic [W-1:0]  mem_next [DEPTH];
    logic          pop_ok;
    logic [CW-1:0] wr_idx;

    assign valid  = (count != '0);
    assign pop_ok = pop && valid;
    assign wr_idx = count - CW'(pop_ok);
    assign head   = valid ? mem[0] : '0;

    // Shift down on pop, then place the new word just behind the surviving entries.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_next[i] = mem[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CW'(i))) begin
                mem_next[i] = push_data;
            end
        end
    end

    // Occupancy; clear wins over any same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential word fetches, buffers in-order
// responses tagged with their PC, and flushes on a downstream redirect.
// Build option: IF_PREFETCH_BUF_EN (two outstanding / two buffered words).
//
// state | meaning
// BOOT  | out of reset, nothing issued; leaves on the first clock edge
// RUN   | sequential fetch, responses written to the buffer
// FLUSH | waiting out stale responses (drop_cnt of them), no requests
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [31:0]        instr_pc,
    output logic [31:0]        instr_npc
);

    localparam int DEPTH = FETCH_DEPTH;
    localparam int CW    = $clog2(DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] out_next;
    logic [CW-1:0] drop_next;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          resp;
    logic          push;
    logic          pop;
    logic [31:0]   resp_pc;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // A word consumed by decode this cycle frees its slot immediately, which
    // is what lets the two-deep build sustain one instruction per cycle.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign imem_req  = (state == RUN) && (in_use < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign out_next  = outstanding + CW'(req_fire) - CW'(resp);
    assign drop_next = drop_cnt - CW'(resp && (drop_cnt != '0));

    // All outstanding requests in RUN are sequential, so the oldest one sits
    // 'outstanding' increments behind the next fetch address.
    assign resp_pc    = fetch_pc - (32'(outstanding) * PC_INC);
    assign push       = resp && (state == RUN) && !redirect;
    assign push_entry = '{pc: resp_pc, instr: imem_rdata};
    assign pop        = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .clear     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .valid     (instr_valid),
        .head      (head_entry),
        .count     (fifo_count)
    );

    assign instruction = head_entry.instr;
    assign instr_pc    = head_entry.pc;
    assign instr_npc   = instr_valid ? (head_entry.pc + PC_INC) : '0;

    // Fetch sequencing: PC, outstanding tracking and flush control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect && (out_next != '0)) begin
                        state    <= FLUSH;
                        drop_cnt <= out_next;
                    end
                end
                FLUSH: begin
                    drop_cnt <= drop_next;
                    if (drop_next == '0) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. The reference model tracks requests as a
// queue of {address, epoch}; a redirect opens a new epoch, and responses from
// older epochs are expected to vanish. Delivered words must match the queue.
module tb_if_stage;

`ifdef IF_PREFETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] exp_q[$];
    int          epoch = 0;
    int          stale = 0;
    bit          booted = 0;
    logic [31:0] exp_fetch = 32'h0;
    int          gnt_pct = 100, resp_pct = 100, rdy_pct = 100;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = 32'h0;
    bit          stray = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_addr = 32'h0;
    int          pops = 0;
    bit          have_first = 0;
    logic [31:0] first_pc = 32'hDEAD_DEAD;
    bit          saw_180 = 0;
    bit          wrap_seen = 0;
    logic [31:0] last_grant = 32'h0;
    int          checks = 0;
    int          errors = 0;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_npc   (instr_npc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic roll(input int pct);
        return int'($urandom_range(100, 1)) <= pct;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic tick();
        logic resp_now;
        logic popd;
        logic exp_valid;
        logic exp_req;
        int   occ;
        req_t e;
        imem_gnt    = roll(gnt_pct);
        resp_now    = (mem_q.size() > 0) && roll(resp_pct);
        imem_rvalid = resp_now || stray;
        imem_rdata  = resp_now ? mem_fn(mem_q[0].addr) : $urandom();
        instr_ready = roll(rdy_pct);
        redirect    = redir_req;
        redirect_pc = redir_tgt;
        #2;
        if (prev_wait) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, prev_addr);
        end
        exp_valid = (exp_q.size() != 0);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
        popd = exp_valid && instr_ready;
        occ = mem_q.size() + exp_q.size() - (popd ? 1 : 0);
        exp_req = booted && (stale == 0) && (occ < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (popd) begin
            chk("instr_pc", instr_pc, exp_q[0]);
            chk("instruction", instruction, mem_fn(exp_q[0]));
            chk("instr_npc", instr_npc, exp_q[0] + 32'd4);
            pops++;
            if (!have_first) begin
                have_first = 1;
                first_pc = instr_pc;
            end
            void'(exp_q.pop_front());
        end
        if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, exp_fetch);
            if (imem_addr == 32'h180) saw_180 = 1;
            if (last_grant == 32'hFFFF_FFFC && imem_addr == 32'h0) wrap_seen = 1;
            last_grant = imem_addr;
            e.addr = exp_fetch;
            e.epoch = epoch;
            mem_q.push_back(e);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (resp_now) begin
            e = mem_q.pop_front();
            if (e.epoch == epoch && !redir_req) exp_q.push_back(e.addr);
            else if (e.epoch != epoch) stale--;
        end
        if (redir_req) begin
            exp_q.delete();
            stale = mem_q.size();
            epoch++;
            exp_fetch = redir_tgt;
        end
        prev_wait = imem_req && !imem_gnt && !redir_req;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
        booted = 1;
        redir_req = 0;
        stray = 0;
    endtask

    // Assert reset (outputs must clear without any clock edge), then release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_npc", instr_npc, 32'd0);
        mem_q.delete();
        exp_q.delete();
        stale = 0;
        booted = 0;
        prev_wait = 0;
        exp_fetch = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        do_reset();

        // Straight-line fetch at single-cycle latency.
        gnt_pct = 100; resp_pct = 100; rdy_pct = 100;
        pops = 0; have_first = 0; first_pc = 32'hDEAD_DEAD;
        repeat (20) tick();
        chk("throughput", 32'(pops), (DEPTH == 2) ? 32'd17 : 32'd9);
        chk("first_pc_after_reset", first_pc, 32'h0);

        // Decode stalls for 5 cycles.
        rdy_pct = 0;
        repeat (5) tick();
        chk("req_dropped_when_full", {31'b0, imem_req}, 32'd0);
        chk("buffer_held", {31'b0, instr_valid}, 32'd1);
        rdy_pct = 100;
        repeat (12) tick();

        // Redirect with DEPTH responses outstanding.
        gnt_pct = 0; resp_pct = 100;
        for (int i = 0; i < 20 && (mem_q.size() > 0 || exp_q.size() > 0); i++) tick();
        gnt_pct = 100; resp_pct = 0;
        for (int i = 0; i < 10 && mem_q.size() < DEPTH; i++) tick();
        chk("req_at_depth", {31'b0, imem_req}, 32'd0);
        redir_req = 1; redir_tgt = 32'h100;
        have_first = 0; first_pc = 32'hDEAD_DEAD;
        tick();
        chk("flush_no_req", {31'b0, imem_req}, 32'd0);
        chk("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
        resp_pct = 100;
        for (int i = 0; i < 20 && !have_first; i++) tick();
        chk("first_pc_0x100", first_pc, 32'h100);

        // Second redirect while still flushing the first.
        resp_pct = 0;
        for (int i = 0; i < 10 && mem_q.size() < DEPTH; i++) tick();
        saw_180 = 0;
        redir_req = 1; redir_tgt = 32'h180;
        tick();
        redir_req = 1; redir_tgt = 32'h200;
        have_first = 0; first_pc = 32'hDEAD_DEAD;
        tick();
        resp_pct = 100;
        for (int i = 0; i < 20 && !have_first; i++) tick();
        chk("first_pc_0x200", first_pc, 32'h200);
        chk("old_target_never_fetched", {31'b0, saw_180}, 32'd0);

        // Address wrap past the top of the address space.
        wrap_seen = 0;
        redir_req = 1; redir_tgt = 32'hFFFF_FFF8;
        repeat (12) tick();
        chk("pc_wrap", {31'b0, wrap_seen}, 32'd1);

        // Randomised traffic with occasional redirects.
        for (int blk = 0; blk < 8; blk++) begin
            gnt_pct  = int'($urandom_range(100, 30));
            resp_pct = int'($urandom_range(100, 30));
            rdy_pct  = int'($urandom_range(100, 30));
            for (int i = 0; i < 50; i++) begin
                if (roll(4)) begin
                    redir_req = 1;
                    redir_tgt = $urandom() & 32'hFFFF_FFFC;
                end
                tick();
            end
        end

        // Reset with a response pending, then stray responses.
        gnt_pct = 100; resp_pct = 0; rdy_pct = 0;
        for (int i = 0; i < 20 && (mem_q.size() < DEPTH || stale != 0); i++) tick();
        if (DEPTH == 2) begin
            resp_pct = 100;
            tick();
        end
        do_reset();
        gnt_pct = 0; resp_pct = 100; rdy_pct = 0;
        stray = 1;
        tick();
        stray = 1;
        tick();
        tick();
        chk("stray_ignored", {31'b0, instr_valid}, 32'd0);
        gnt_pct = 100; rdy_pct = 100;
        have_first = 0; first_pc = 32'hDEAD_DEAD;
        repeat (10) tick();
        chk("restart_first_pc", first_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
